// File: rtl/barrel_unshifter_seq.sv
// ============================================================================
// Module      : barrel_unshifter_seq
// Description : Iterative inverse of the 8-bit barrel shifter function set.
//               Undoes one bit position per clock and reports recoverable bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module barrel_unshifter_seq #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_amount,
    input  logic [3:0]         in_function,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [WIDTH-1:0]   out_mask,
    output logic               out_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Direction of the inverse step applied to the working register
    typedef enum logic [2:0] {
        KIND_PASS = 3'd0,
        KIND_SHR  = 3'd1,
        KIND_SHL  = 3'd2,
        KIND_ROR  = 3'd3,
        KIND_ROL  = 3'd4
    } kind_t;

    localparam logic [WIDTH-1:0]   ALL_ONES = '1;
    localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1);

    state_t             state;
    state_t             next_state;
    kind_t              op;
    kind_t              dec_kind;
    logic [WIDTH-1:0]   dec_mask;
    logic               dec_err;
    logic               go_shift;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   step;
    logic [WIDTH-1:0]   mask_hold;
    logic [SHAMT_W-1:0] cnt;

    always_comb begin
        dec_kind = KIND_PASS;
        dec_mask = ALL_ONES;
        dec_err  = 1'b0;
        case (in_function)
            4'b0000: dec_kind = KIND_PASS;
            4'b0001, 4'b0011, 4'b0111: begin
                dec_kind = KIND_SHR;
                dec_mask = ALL_ONES >> in_amount;
            end
            4'b0010, 4'b0100, 4'b1000: begin
                dec_kind = KIND_SHL;
                dec_mask = ALL_ONES << in_amount;
            end
            4'b0101: dec_kind = KIND_ROR;
            4'b0110: dec_kind = KIND_ROL;
            default: begin
                dec_mask = '0;
                dec_err  = 1'b1;
            end
        endcase
    end

    assign go_shift = !dec_err && (dec_kind != KIND_PASS) && (in_amount != '0);

    always_comb begin
        step = work;
        case (op)
            KIND_SHR: step = {1'b0, work[WIDTH-1:1]};
            KIND_SHL: step = {work[WIDTH-2:0], 1'b0};
            KIND_ROR: step = {work[0], work[WIDTH-1:1]};
            KIND_ROL: step = {work[WIDTH-2:0], work[WIDTH-1]};
            default:  step = work;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = go_shift ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (cnt == CNT_ONE) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Result registers change only when DONE is entered
    always_ff @(posedge clk) begin
        if (rst) begin
            work      <= '0;
            op        <= KIND_PASS;
            cnt       <= '0;
            mask_hold <= '0;
            out_data  <= '0;
            out_mask  <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work      <= in_data;
                        op        <= dec_kind;
                        cnt       <= in_amount;
                        mask_hold <= dec_mask;
                        if (!go_shift) begin
                            out_data <= dec_err ? '0 : in_data;
                            out_mask <= dec_mask;
                            out_err  <= dec_err;
                        end
                    end
                end
                SHIFT: begin
                    work <= step;
                    cnt  <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        out_data <= step;
                        out_mask <= mask_hold;
                        out_err  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_barrel_unshifter_seq.sv
// ============================================================================
// Module      : tb_barrel_unshifter_seq
// Description : Scoreboard bench for barrel_unshifter_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_barrel_unshifter_seq;

    localparam int WIDTH   = 8;
    localparam int SHAMT_W = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_amount;
    logic [3:0]         in_function;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [WIDTH-1:0]   out_mask;
    logic               out_err;

    typedef struct {
        logic [7:0] d;
        logic [7:0] m;
        logic       e;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    barrel_unshifter_seq #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_amount   (in_amount),
        .in_function (in_function),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_mask    (out_mask),
        .out_err     (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] fn, input logic [2:0] n, input logic [7:0] d);
        exp_t        r;
        logic [15:0] dd;
        logic [7:0]  ones;
        ones  = 8'hFF;
        dd    = {d, d};
        r.e   = 1'b0;
        r.lat = int'(n);
        case (fn)
            4'b0000: begin r.d = d; r.m = ones; r.lat = 0; end
            4'b0001, 4'b0011, 4'b0111: begin r.d = d >> n; r.m = ones >> n; end
            4'b0010, 4'b0100, 4'b1000: begin r.d = d << n; r.m = ones << n; end
            4'b0101: begin dd = dd >> n; r.d = dd[7:0];  r.m = ones; end
            4'b0110: begin dd = dd << n; r.d = dd[15:8]; r.m = ones; end
            default: begin r.d = 8'h00; r.m = 8'h00; r.e = 1'b1; r.lat = 0; end
        endcase
        return r;
    endfunction

    task automatic send(input logic [3:0] fn, input logic [2:0] n, input logic [7:0] d);
        exp_t e;
        int   waited;
        int   lat;
        e = model(fn, n, d);
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            return;
        end
        in_function = fn;
        in_amount   = n;
        in_data     = d;
        in_valid    = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_data     = ~d;
        in_function = 4'b1111;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, e.lat);
    endtask

    task automatic collect(input int hold);
        exp_t e;
        check("out_valid", {31'd0, out_valid}, 32'd1);
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check("out_data", {24'd0, out_data}, {24'd0, e.d});
        check("out_mask", {24'd0, out_mask}, {24'd0, e.m});
        check("out_err",  {31'd0, out_err},  {31'd0, e.e});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_data",  {24'd0, out_data},  {24'd0, e.d});
            check("hold_mask",  {24'd0, out_mask},  {24'd0, e.m});
            check("hold_ready", {31'd0, in_ready},  32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("handoff_valid", {31'd0, out_valid}, 32'd0);
        check("handoff_ready", {31'd0, in_ready},  32'd1);
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        in_amount   = '0;
        in_function = '0;
        out_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ready", {31'd0, in_ready},  32'd1);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data",  {24'd0, out_data},  32'd0);
        check("rst_mask",  {24'd0, out_mask},  32'd0);
        check("rst_err",   {31'd0, out_err},   32'd0);

        send(4'b0101, 3'd3, 8'h2D); collect(0);
        send(4'b0001, 3'd2, 8'h94); collect(0);
        send(4'b0011, 3'd2, 8'h94); collect(0);
        send(4'b0111, 3'd2, 8'h94); collect(0);
        send(4'b0100, 3'd4, 8'h0A); collect(0);
        send(4'b0010, 3'd4, 8'h0A); collect(0);
        send(4'b1000, 3'd4, 8'h0A); collect(0);
        send(4'b0110, 3'd1, 8'hD2); collect(0);
        send(4'b0000, 3'd5, 8'h3C); collect(0);
        send(4'b1111, 3'd7, 8'h5A); collect(0);
        send(4'b0001, 3'd0, 8'hC3); collect(0);
        send(4'b0110, 3'd7, 8'h81); collect(10);

        // Reset arrives on the third shift edge of a long rotate
        @(negedge clk);
        in_function = 4'b0101;
        in_amount   = 3'd7;
        in_data     = 8'h96;
        in_valid    = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_ready", {31'd0, in_ready},  32'd1);
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_data",  {24'd0, out_data},  32'd0);
        check("midrst_mask",  {24'd0, out_mask},  32'd0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 check("midrst_stale", {31'd0, out_valid}, 32'd0);
        end

        for (int i = 0; i < 24; i++) begin
            send(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 8'($urandom));
            collect(int'($urandom_range(0, 2)));
        end

        check("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/barrel_unshifter_seq.md
Name: barrel_unshifter_seq

Overview:
Iterative inverse of the 8-bit barrel shifter function set. It accepts a shifted word plus the function code and amount that produced it, and reconstructs the pre-shift word. It also reports which result bits are recoverable. One bit position is processed per clock, with a valid/ready handshake on both sides; it sits on the datapath return leg that undoes shifter operations.

Parameters:
WIDTH, 8, data width; must equal 2**SHAMT_W.
SHAMT_W, 3, shift-amount width.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  request valid.
in_ready  output  1  block can accept a request (high only in IDLE).
in_data  input  WIDTH  shifted word to undo.
in_amount  input  SHAMT_W  shift amount originally applied.
in_function  input  4  function code originally applied.
out_valid  output  1  result valid; held until out_ready.
out_ready  input  1  consumer accepts result.
out_data  output  WIDTH  reconstructed word; unknown bits forced to 0.
out_mask  output  WIDTH  1 = corresponding out_data bit is recovered exactly.
out_err  output  1  unsupported function code.

Behaviour:
- Reset (clk edge with rst=1): state=IDLE, out_data=0, out_mask=0, out_valid=0, out_err=0, in_ready=1. Reset aborts any operation in flight; no result is emitted.
- Inverse mapping (n = in_amount):
  - 0000 pass: no shift, mask all ones.
  - 0001 / 0011 / 0111 (shift-left codes): logical shift right by n, mask = all-ones >> n.
  - 0010 / 0100 / 1000 (logical shift-right codes; 0010 is logical because data is unsigned): logical shift left by n, mask = all-ones << n.
  - 0101 rotate-left: rotate right by n, mask all ones.
  - 0110 rotate-right: rotate left by n, mask all ones.
  - Any other code: out_data=0, out_mask=0, out_err=1, no shifting, regardless of n.
- Unknown bit positions (mask=0) in out_data are 0. This follows naturally from zero-fill logical shifts.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: in_ready=1. On in_valid, capture in_data into the working register, latch the operation, compute the mask, and load cnt=n.
    - Go to SHIFT if n!=0 and the code is a shifting code.
    - Otherwise go to DONE; this covers pass, n=0, and err.
  - SHIFT: each edge, move the working register one bit in the inverse direction (zero-fill or wrap per the code) and decrement cnt. On the edge where cnt goes 1->0, go to DONE.
  - DONE: out_valid=1; out_data, out_mask and out_err are stable. On out_ready, go to IDLE and clear out_valid. in_ready stays 0 in DONE, so a new request cannot be accepted in the same cycle as the handoff.
- Latency: request accepted at edge E. out_valid is high in the cycle following edge E+n for shifting codes, and following edge E for pass/n=0/err. Worst case is 7 shift edges.
- Throughput: one request in flight. The minimum request interval is n+2 cycles with out_ready held high.
- out_data, out_mask and out_err are registered outputs. They update only on entry to DONE and hold their values through IDLE until the next result.
- Inputs are sampled only on the accept edge; changes to in_* during SHIFT/DONE have no effect.
- in_valid while in_ready=0 is ignored; the requester must hold the request.

Test Plan:
- Rotate inverse: fn=0101, amt=3, data=8'h2D -> out_data=8'hA5, out_mask=8'hFF, out_err=0. out_valid appears after 3 shift edges.
- Shift-left inverse: fn=0001, amt=2, data=8'h94 -> out_data=8'h25, out_mask=8'h3F. Repeat with fn=0011 and fn=0111 for identical results.
- Shift-right inverse: fn=0100, amt=4, data=8'h0A -> out_data=8'hA0, out_mask=8'hF0. Repeat with fn=0010 and fn=1000 for identical results. Rotate-right inverse: fn=0110, amt=1, data=8'hD2 -> 8'hA5.
- Edge/error cases:
  - fn=0000, amt=5, data=8'h3C -> 8'h3C, mask 8'hFF, out_valid one cycle after accept.
  - fn=1111, amt=7 -> out_data=0, mask=0, out_err=1, out_valid one cycle after accept.
- Backpressure: hold out_ready=0 for 10 cycles after the result -> out_valid and outputs stay constant and in_ready stays 0. Raise out_ready -> IDLE next edge, then accept the next request.
- Reset mid-op: fn=0101, amt=7, assert rst at the 3rd shift edge -> next cycle IDLE, in_ready=1, out_valid=0, out_data=0, out_mask=0. No stale result appears afterwards.
